// File: rtl/bus_width_decrease.sv
// Serializing stage: accepts one SIZE_IN word per handshake and emits SIZE_IN/SIZE_OUT slices.
// Optional `BUS_WIDTH_DECREASE_REG_READY_EN adds a one-word skid so input_ready comes from a flop.
module bus_width_decrease #(
  parameter int unsigned SIZE_IN       = 32,
  parameter int unsigned SIZE_OUT      = 8,
  parameter bit          LITTLE_ENDIAN = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                input_ready,
  input  logic                input_valid,
  input  logic [SIZE_IN-1:0]  data_in,
  input  logic                output_ready,
  output logic                output_valid,
  output logic [SIZE_OUT-1:0] data_out,
  output logic                output_last
);

  localparam int unsigned RATIO  = SIZE_IN / SIZE_OUT;
  localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  if (((SIZE_IN % SIZE_OUT) != 0) || (RATIO < 2)) begin : g_cfg_check
    $error("bus_width_decrease: SIZE_IN must be a multiple of SIZE_OUT with a ratio of at least 2");
  end

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SIZE_IN-1:0]  word_q, word_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]   slice_idx;
  logic                busy, last_beat, in_hs, out_hs;

  assign busy      = (state_q == S_ACTIVE);
  assign last_beat = (beat_q == LAST_BEAT);
  assign in_hs     = input_valid && input_ready;
  assign out_hs    = busy && output_ready;

  assign output_valid = busy;
  assign output_last  = busy && last_beat;

`ifdef BUS_WIDTH_DECREASE_REG_READY_EN
  logic [SIZE_IN-1:0] skid_q, skid_d;
  logic               skid_full_q, skid_full_d;

  assign input_ready = !skid_full_q;
`else
  assign input_ready = !busy || (last_beat && output_ready);
`endif

  // Beat 0 is the most-significant slice unless LITTLE_ENDIAN reverses the order.
  always_comb begin
    slice_idx = LITTLE_ENDIAN ? beat_q : (LAST_BEAT - beat_q);
    data_out  = '0;
    if (busy) begin
      data_out = word_q[slice_idx*SIZE_OUT +: SIZE_OUT];
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    beat_d  = beat_q;
`ifdef BUS_WIDTH_DECREASE_REG_READY_EN
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_hs) begin
          word_d  = data_in;
          beat_d  = '0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (out_hs && !last_beat) begin
          beat_d = beat_q + 1'b1;
        end else if (out_hs) begin
          beat_d = '0;
`ifdef BUS_WIDTH_DECREASE_REG_READY_EN
          if (skid_full_q) begin
            word_d      = skid_q;
            skid_full_d = 1'b0;
          end else if (in_hs) begin
            word_d = data_in;
          end else begin
            state_d = S_IDLE;
          end
`else
          if (in_hs) begin
            word_d = data_in;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end
`ifdef BUS_WIDTH_DECREASE_REG_READY_EN
        // Words arriving mid-serialization park in the skid; only an empty skid on the last beat bypasses it.
        if (in_hs && !(out_hs && last_beat)) begin
          skid_d      = data_in;
          skid_full_d = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
    end
  end

`ifdef BUS_WIDTH_DECREASE_REG_READY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else begin
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end
`endif

endmodule
